seg7_sum_scanner: RTL

- Downstream consumer of the 4-bit ripple adder's sum nibble and carry-out.
- Captures the 5-bit result {co, s[3:0]} on a load strobe and drives a 4-digit common-anode seven-segment display by time-multiplexing.
- Shows decimal ones/tens, a carry flag glyph and the raw hex nibble.
- Sits between the adder datapath and the board's display pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seg7_sum_scanner.sv | 106 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment sum scanner: active-low glyphs
// in {g,f,e,d,c,b,a} order, anode patterns and digit slot indices.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0   = 7'b1000000;
  localparam logic [6:0] GLYPH_1   = 7'b1111001;
  localparam logic [6:0] GLYPH_2   = 7'b0100100;
  localparam logic [6:0] GLYPH_3   = 7'b0110000;
  localparam logic [6:0] GLYPH_4   = 7'b0011001;
  localparam logic [6:0] GLYPH_5   = 7'b0010010;
  localparam logic [6:0] GLYPH_6   = 7'b0000010;
  localparam logic [6:0] GLYPH_7   = 7'b1111000;
  localparam logic [6:0] GLYPH_8   = 7'b0000000;
  localparam logic [6:0] GLYPH_9   = 7'b0010000;
  localparam logic [6:0] GLYPH_A   = 7'b0001000;
  localparam logic [6:0] GLYPH_B   = 7'b0000011;
  localparam logic [6:0] GLYPH_C   = 7'b1000110;
  localparam logic [6:0] GLYPH_D   = 7'b0100001;
  localparam logic [6:0] GLYPH_E   = 7'b0000110;
  localparam logic [6:0] GLYPH_F   = 7'b0001110;
  localparam logic [6:0] GLYPH_OFF = 7'b1111111;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_CARRY = 2'd2;
  localparam logic [1:0] DIG_HEX   = 2'd3;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_OFF;
    case (code_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = GLYPH_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_sum_scanner.sv
// Captures the adder result {carry, sum} and time-multiplexes it onto a
// 4-digit common-anode display: decimal ones, decimal tens, carry 'C', hex.
module seg7_sum_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sum_in,
  input  logic       carry_in,
  input  logic       load,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [4:0]       value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [3:0] tens, ones;
  logic [4:0] tensTimesTen;
  logic [3:0] digitCode;
  logic [6:0] glyph;
  logic       digitOn;

  // Decimal split of 0..31 by threshold, avoiding a real divider.
  always_comb begin
    tens         = 4'd0;
    tensTimesTen = 5'd0;
    if (value_q >= 5'd30) begin
      tens         = 4'd3;
      tensTimesTen = 5'd30;
    end else if (value_q >= 5'd20) begin
      tens         = 4'd2;
      tensTimesTen = 5'd20;
    end else if (value_q >= 5'd10) begin
      tens         = 4'd1;
      tensTimesTen = 5'd10;
    end
    ones = 4'(value_q - tensTimesTen);
  end

  // The carry slot reuses the decoder: hex C has the same shape as the carry glyph.
  always_comb begin
    digitCode = ones;
    digitOn   = 1'b1;
    case (idx_q)
      DIG_ONES:  begin digitCode = ones;          digitOn = 1'b1;          end
      DIG_TENS:  begin digitCode = tens;          digitOn = (tens != 4'd0); end
      DIG_CARRY: begin digitCode = 4'hC;          digitOn = value_q[4];    end
      DIG_HEX:   begin digitCode = value_q[3:0];  digitOn = 1'b1;          end
      default:   begin digitCode = ones;          digitOn = 1'b1;          end
    endcase
  end

  hex_to_seg7 u_decoder (
    .code_i (digitCode),
    .seg_o  (glyph)
  );

  always_comb begin
    value_d = load ? {carry_in, sum_in} : value_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = ANODES_OFF;
    seg_d = GLYPH_OFF;
    if (digitOn && !blank) begin
      an_d        = ANODES_OFF;
      an_d[idx_q] = 1'b0;
      seg_d       = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= ANODES_OFF;
      seg_q   <= GLYPH_OFF;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
